// File: rtl/sorter_pkg.sv
// Shared types and helpers for the serial bubble sorter.
// The early-exit option is selected in the top with SORTER_EARLY_EXIT_EN.
package sorter_pkg;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  // Elements are widened to this size before comparison, so W must not exceed it.
  localparam int CMP_W = 64;

  // Swap counter width: must hold 0 .. N(N-1)/2.
  function automatic int sorter_cw(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

  // Returns 1 when a (lower index) and b are strictly out of order and must swap.
  function automatic logic cmp_gt(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             sgn,
                                  input logic             desc);
    logic gt;
    logic lt;
    gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    return desc ? lt : gt;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational two-element compare-swap: lo goes to the lower index, hi to the upper.
// Equal elements never swap, which keeps the overall sort stable.
module sort_cmp_swap
  import sorter_pkg::*;
#(
  parameter int W          = 4,
  parameter int SIGNED     = 0,
  parameter int DESCENDING = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  logic [CMP_W-1:0] a_ext;
  logic [CMP_W-1:0] b_ext;

  if (SIGNED != 0) begin : g_sext
    assign a_ext = CMP_W'($signed(a));
    assign b_ext = CMP_W'($signed(b));
  end else begin : g_zext
    assign a_ext = CMP_W'(a);
    assign b_ext = CMP_W'(b);
  end

  assign swapped = cmp_gt(a_ext, b_ext, SIGNED != 0, DESCENDING != 0);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/serial_bubble_sorter.sv
// Sequential bubble sorter: one compare-swap per clock over an N-entry array.
// Define SORTER_EARLY_EXIT_EN to finish after the first pass that makes no swap.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// SORT  | one compare-swap of arr[idx], arr[idx+1] per cycle
// DONE  | sorted vector presented, waiting for out_ready
module serial_bubble_sorter
  import sorter_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 4,
  parameter int SIGNED     = 0,
  parameter int DESCENDING = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*W-1:0]          out_data,
  output logic                    busy,
  output logic [sorter_cw(N)-1:0] swap_cnt
);

  localparam int CW = sorter_cw(N);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] MAX_SWAPS = CW'(N * (N - 1) / 2);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   arr [N];
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_b;
  logic [IW-1:0]  pass;
  logic [IW-1:0]  last_idx;
  logic           pass_end;
  logic           sort_done;
  logic           accept;
  logic           swapped;
  logic [W-1:0]   lo;
  logic [W-1:0]   hi;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SORT);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign idx_b    = idx + 1'b1;
  assign last_idx = LAST_PASS - pass;
  assign pass_end = (idx == last_idx);

  sort_cmp_swap #(
    .W          (W),
    .SIGNED     (SIGNED),
    .DESCENDING (DESCENDING)
  ) u_cmp (
    .a       (arr[idx]),
    .b       (arr[idx_b]),
    .lo      (lo),
    .hi      (hi),
    .swapped (swapped)
  );

`ifdef SORTER_EARLY_EXIT_EN
  logic swapped_q;
  logic pass_swapped;

  // The flag from the previous pass is ignored at idx 0, which clears it per pass.
  assign pass_swapped = swapped || ((idx != '0) && swapped_q);
  assign sort_done    = pass_end && (!pass_swapped || (pass == LAST_PASS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swapped_q <= 1'b0;
    end else if (busy) begin
      swapped_q <= pass_swapped;
    end
  end
`else
  assign sort_done = pass_end && (pass == LAST_PASS);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = SORT;
      SORT:    if (sort_done) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Only a finished result is ever visible on out_data.
  always_comb begin
    out_data = '0;
    if (state == DONE) begin
      for (int k = 0; k < N; k++) out_data[k*W +: W] = arr[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pass     <= '0;
      swap_cnt <= '0;
      for (int k = 0; k < N; k++) arr[k] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        for (int k = 0; k < N; k++) arr[k] <= in_data[k*W +: W];
        idx      <= '0;
        pass     <= '0;
        swap_cnt <= '0;
      end else if (busy) begin
        arr[idx]   <= lo;
        arr[idx_b] <= hi;
        if (swapped && (swap_cnt != MAX_SWAPS)) swap_cnt <= swap_cnt + 1'b1;
        if (pass_end) begin
          idx  <= '0;
          pass <= pass + 1'b1;
        end else begin
          idx <= idx_b;
        end
      end
    end
  end

endmodule
